// File: rtl/usart_arbiter.sv
// usart_arbiter: round-robin arbiter that lets two masters share the
// supervisor USART's 8-bit register bus. One single-byte transaction runs
// at a time. Each transaction drives an active-low strobe for a fixed
// width, then holds both strobes high for a fixed recovery time. Read data
// is captured while the strobe is still low, and the owning port gets a
// one-cycle acknowledge.
module usart_arbiter #(
  parameter int STROBE_CYCLES  = 3,  // strobe low width in clocks, 2..15
  parameter int RECOVER_CYCLES = 2   // recovery high width in clocks, 1..15
) (
  input  logic       busclk_i,
  input  logic       reset_i,
  // port 0: Z80 host I/O decoder
  input  logic       req0_i,
  input  logic       we0_i,
  input  logic [3:0] adr0_i,
  input  logic [7:0] wdat0_i,
  output logic       ack0_o,
  output logic [7:0] rdat0_o,
  // port 1: monitor / IPL sequencer
  input  logic       req1_i,
  input  logic       we1_i,
  input  logic [3:0] adr1_i,
  input  logic [7:0] wdat1_i,
  output logic       ack1_o,
  output logic [7:0] rdat1_o,
  // USART side
  output logic [3:0] A_o,
  output logic [7:0] D_o,
  input  logic [7:0] D_i,
  output logic       nWR_o,
  output logic       nRD_o,
  output logic       busy_o,
  output logic       gnt_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] STROBE  = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  // The counter runs from load value down to zero inclusive, so a phase
  // lasts exactly (load + 1) clocks.
  localparam logic [3:0] STROBE_LOAD  = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;

  logic       any_req;
  logic       winner;
  logic       win_we;
  logic [3:0] win_adr;
  logic [7:0] win_wdat;

  // Pick the port to serve next and route its request fields.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    any_req  = req0_i | req1_i;
    winner   = 1'b0;
    if (req0_i && req1_i) begin
      // Contention goes to the port that was not served last.
      winner = ~gnt_o;
    end else begin
      // Sole requester wins; port 1 alone means winner = 1.
      winner = req1_i;
    end
    win_we   = winner ? we1_i   : we0_i;
    win_adr  = winner ? adr1_i  : adr0_i;
    win_wdat = winner ? wdat1_i : wdat0_i;
  end

  // Transaction sequencer: grant, strobe, capture/ack, recovery.
  // NOTE: sequential state uses non-blocking assignments, so every register updates from pre-edge values.
  always_ff @(posedge busclk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      nWR_o   <= 1'b1;
      nRD_o   <= 1'b1;
      A_o     <= 4'd0;
      D_o     <= 8'd0;
      ack0_o  <= 1'b0;
      ack1_o  <= 1'b0;
      rdat0_o <= 8'd0;
      rdat1_o <= 8'd0;
      busy_o  <= 1'b0;
      // Treating port 1 as last served makes port 0 win the first contention.
      gnt_o   <= 1'b1;
    end else begin
      // Acks are single-cycle pulses unless re-asserted below.
      ack0_o <= 1'b0;
      ack1_o <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            A_o    <= win_adr;
            D_o    <= win_wdat;
            gnt_o  <= winner;
            nWR_o  <= ~win_we;
            nRD_o  <= win_we;
            cnt    <= STROBE_LOAD;
            state  <= STROBE;
            busy_o <= 1'b1;
          end
        end

        STROBE: begin
          if (cnt == 4'd0) begin
            // The strobe is still low in this cycle, so D_i is valid now.
            if (!nRD_o) begin
              if (gnt_o) rdat1_o <= D_i;
              else       rdat0_o <= D_i;
            end
            if (gnt_o) ack1_o <= 1'b1;
            else       ack0_o <= 1'b1;
            nWR_o <= 1'b1;
            nRD_o <= 1'b1;
            cnt   <= RECOVER_LOAD;
            state <= RECOVER;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RECOVER: begin
          if (cnt == 4'd0) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          nWR_o  <= 1'b1;
          nRD_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_arbiter.sv
// tb_usart_arbiter: self-checking bench for usart_arbiter. A table of
// single transactions with constant expected read-back values drives the
// default instance. Hand-written sequences cover contention, a continuous
// single requester, reset mid-strobe, and a second instance with
// STROBE_CYCLES=5 and RECOVER_CYCLES=1. A scoreboard queue holds the
// expected grant order. A negedge monitor checks strobe widths, recovery
// gaps, bus contents and every acknowledge against that queue.
module tb_usart_arbiter;

  localparam int S  = 3;
  localparam int R  = 2;
  localparam int S2 = 5;
  localparam int R2 = 1;

  typedef struct {
    bit         port;
    bit         we;
    logic [3:0] adr;
    logic [7:0] wdat;
    logic [7:0] dval;
    logic [7:0] exp_rdat0;
    logic [7:0] exp_rdat1;
  } vec_t;

  typedef struct {
    bit         port;
    bit         we;
    logic [3:0] adr;
    logic [7:0] wdat;
    logic [7:0] rdat0;
    logic [7:0] rdat1;
  } exp_t;

  logic clk;
  logic rst;

  // default instance signals
  logic       req0, we0, req1, we1;
  logic [3:0] adr0, adr1;
  logic [7:0] wdat0, wdat1;
  logic       ack0, ack1;
  logic [7:0] rdat0, rdat1;
  logic [3:0] a_out;
  logic [7:0] d_out;
  logic [7:0] d_in;
  logic       nwr, nrd, busy, gnt;

  // second instance signals
  logic       req0_b, we0_b, req1_b, we1_b;
  logic [3:0] adr0_b, adr1_b;
  logic [7:0] wdat0_b, wdat1_b;
  logic       ack0_b, ack1_b;
  logic [7:0] rdat0_b, rdat1_b;
  logic [3:0] a_out_b;
  logic [7:0] d_out_b;
  logic [7:0] d_in_b;
  logic       nwr_b, nrd_b, busy_b, gnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb[$];
  int   ack_count = 0;

  // strobe monitor state
  bit in_low   = 0;
  bit have_rel = 0;
  int low_cnt  = 0;
  int high_cnt = 0;
  int gap_min  = 999;
  int gap_max  = 0;

  usart_arbiter #(.STROBE_CYCLES(S), .RECOVER_CYCLES(R)) dut (
    .busclk_i(clk), .reset_i(rst),
    .req0_i(req0), .we0_i(we0), .adr0_i(adr0), .wdat0_i(wdat0),
    .ack0_o(ack0), .rdat0_o(rdat0),
    .req1_i(req1), .we1_i(we1), .adr1_i(adr1), .wdat1_i(wdat1),
    .ack1_o(ack1), .rdat1_o(rdat1),
    .A_o(a_out), .D_o(d_out), .D_i(d_in),
    .nWR_o(nwr), .nRD_o(nrd), .busy_o(busy), .gnt_o(gnt)
  );

  usart_arbiter #(.STROBE_CYCLES(S2), .RECOVER_CYCLES(R2)) dut_b (
    .busclk_i(clk), .reset_i(rst),
    .req0_i(req0_b), .we0_i(we0_b), .adr0_i(adr0_b), .wdat0_i(wdat0_b),
    .ack0_o(ack0_b), .rdat0_o(rdat0_b),
    .req1_i(req1_b), .we1_i(we1_b), .adr1_i(adr1_b), .wdat1_i(wdat1_b),
    .ack1_o(ack1_b), .rdat1_o(rdat1_b),
    .A_o(a_out_b), .D_o(d_out_b), .D_i(d_in_b),
    .nWR_o(nwr_b), .nRD_o(nrd_b), .busy_o(busy_b), .gnt_o(gnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no end of test, required $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit p, bit w, logic [3:0] a, logic [7:0] wd,
                              logic [7:0] dv, logic [7:0] e0, logic [7:0] e1);
    vec_t v;
    v.port = p; v.we = w; v.adr = a; v.wdat = wd; v.dval = dv;
    v.exp_rdat0 = e0; v.exp_rdat1 = e1;
    return v;
  endfunction

  task automatic push_exp(bit p, bit w, logic [3:0] a, logic [7:0] wd,
                          logic [7:0] r0, logic [7:0] r1);
    exp_t e;
    e.port = p; e.we = w; e.adr = a; e.wdat = wd; e.rdat0 = r0; e.rdat1 = r1;
    sb.push_back(e);
  endtask

  // Strobe shape, bus contents and acknowledges, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      in_low   = 0;
      have_rel = 0;
      low_cnt  = 0;
      high_cnt = 0;
    end else begin
      if (!nwr && !nrd) check("both_strobes_low", 1, 0);
      if (!nwr || !nrd) begin
        if (!in_low) begin
          if (have_rel) begin
            check("recovery_min", high_cnt >= R + 1, 1);
            if (high_cnt < gap_min) gap_min = high_cnt;
            if (high_cnt > gap_max) gap_max = high_cnt;
          end
          in_low  = 1;
          low_cnt = 0;
          check("busy_in_strobe", busy, 1);
          if (sb.size() == 0) begin
            check("strobe_without_request", 1, 0);
          end else begin
            check("strobe_gnt", gnt, sb[0].port);
            check("strobe_adr", a_out, sb[0].adr);
            check("strobe_kind", {nwr, nrd}, sb[0].we ? 2'b01 : 2'b10);
            if (sb[0].we) check("strobe_wdat", d_out, sb[0].wdat);
          end
        end
        low_cnt++;
      end else begin
        if (in_low) begin
          check("strobe_width", low_cnt, S);
          in_low   = 0;
          have_rel = 1;
          high_cnt = 0;
        end
        high_cnt++;
      end

      if (ack0 && ack1) check("ack_both", 1, 0);
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          check("ack_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_port", ack1, e.port);
          check("ack_gnt", gnt, e.port);
          check("ack_rdat0", rdat0, e.rdat0);
          check("ack_rdat1", rdat1, e.rdat1);
        end
        ack_count++;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!busy) return;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_acks(input int target);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ack_count >= target) return;
    end
    check("ack_timeout", ack_count, target);
  endtask

  // One transaction with an ack latency measurement. D_i carries the read
  // value only while nRD_o is low, so capture outside the strobe is caught.
  task automatic do_txn(input vec_t v);
    int lat;
    wait_idle();
    push_exp(v.port, v.we, v.adr, v.wdat, v.exp_rdat0, v.exp_rdat1);
    d_in = 8'h66;
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; adr1 = v.adr; wdat1 = v.wdat;
    end else begin
      req0 = 1'b1; we0 = v.we; adr0 = v.adr; wdat0 = v.wdat;
    end
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      d_in = !nrd ? v.dval : 8'h66;
      if (v.port ? ack1 : ack0) begin
        lat  = i;
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("ack_latency", lat, S + 1);
  endtask

  vec_t vecs[7];

  initial begin
    int first_low, rel, ack_i, second, base;

    vecs[0] = mk(1'b0, 1'b1, 4'h0, 8'h5A, 8'h00, 8'h00, 8'h00);
    vecs[1] = mk(1'b1, 1'b0, 4'h1, 8'h00, 8'hF3, 8'h00, 8'hF3);
    vecs[2] = mk(1'b0, 1'b0, 4'h2, 8'h00, 8'h3C, 8'h3C, 8'hF3);
    vecs[3] = mk(1'b1, 1'b1, 4'hF, 8'hA5, 8'h00, 8'h3C, 8'hF3);
    vecs[4] = mk(1'b0, 1'b1, 4'h1, 8'hFF, 8'h00, 8'h3C, 8'hF3);
    vecs[5] = mk(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 8'h3C, 8'h00);
    vecs[6] = mk(1'b0, 1'b0, 4'hE, 8'h00, 8'h81, 8'h81, 8'h00);

    rst = 1'b1;
    req0 = 0; we0 = 0; adr0 = 0; wdat0 = 0;
    req1 = 0; we1 = 0; adr1 = 0; wdat1 = 0;
    d_in = 8'h00;
    req0_b = 0; we0_b = 0; adr0_b = 0; wdat0_b = 0;
    req1_b = 0; we1_b = 0; adr1_b = 0; wdat1_b = 0;
    d_in_b = 8'h00;

    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    check("rst_nwr", nwr, 1);
    check("rst_nrd", nrd, 1);
    check("rst_adr", a_out, 0);
    check("rst_dout", d_out, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rdat0", rdat0, 0);
    check("rst_rdat1", rdat1, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt, 1);
    check("rst_b_nwr", nwr_b, 1);
    check("rst_b_gnt", gnt_b, 1);
    rst = 1'b0;

    // Table of isolated transactions
    for (int k = 0; k < 7; k++) do_txn(vecs[k]);
    wait_idle();
    check("table_drained", sb.size(), 0);

    // Both ports requesting from reset: grants alternate 0,1,0,1
    @(posedge clk); #1;
    rst = 1'b1;
    req0 = 1; we0 = 1; adr0 = 4'h3; wdat0 = 8'h11;
    req1 = 1; we1 = 1; adr1 = 4'h4; wdat1 = 8'h22;
    push_exp(1'b0, 1'b1, 4'h3, 8'h11, 8'h00, 8'h00);
    push_exp(1'b1, 1'b1, 4'h4, 8'h22, 8'h00, 8'h00);
    push_exp(1'b0, 1'b1, 4'h3, 8'h11, 8'h00, 8'h00);
    push_exp(1'b1, 1'b1, 4'h4, 8'h22, 8'h00, 8'h00);
    gap_min = 999; gap_max = 0;
    base = ack_count;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_acks(base + 4);
    req0 = 0; req1 = 0;
    wait_idle();
    check("contention_drained", sb.size(), 0);
    check("contention_gap_min", gap_min, R + 1);
    check("contention_gap_max", gap_max, R + 1);

    // Port 0 requesting continuously: back-to-back, gap exactly R+1
    push_exp(1'b0, 1'b1, 4'h5, 8'h77, 8'h00, 8'h00);
    push_exp(1'b0, 1'b1, 4'h5, 8'h77, 8'h00, 8'h00);
    push_exp(1'b0, 1'b1, 4'h5, 8'h77, 8'h00, 8'h00);
    gap_min = 999; gap_max = 0;
    base = ack_count;
    req0 = 1; we0 = 1; adr0 = 4'h5; wdat0 = 8'h77;
    wait_acks(base + 3);
    req0 = 0;
    wait_idle();
    check("single_drained", sb.size(), 0);
    check("single_gap_min", gap_min, R + 1);
    check("single_gap_max", gap_max, R + 1);

    // Reset during the second strobe cycle discards the transaction
    push_exp(1'b0, 1'b1, 4'h6, 8'h99, 8'h00, 8'h00);
    base = ack_count;
    req0 = 1; we0 = 1; adr0 = 4'h6; wdat0 = 8'h99;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!nwr) break;
    end
    check("abort_strobe_seen", nwr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0 = 0;
    check("abort_nwr", nwr, 1);
    check("abort_nrd", nrd, 1);
    check("abort_busy", busy, 0);
    check("abort_ack0", ack0, 0);
    check("abort_gnt", gnt, 1);
    check("abort_adr", a_out, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_ack", ack_count, base);
    do_txn(mk(1'b0, 1'b1, 4'h7, 8'hC5, 8'h00, 8'h00, 8'h00));
    wait_idle();
    check("abort_drained", sb.size(), 0);

    // STROBE_CYCLES=5, RECOVER_CYCLES=1 instance, port 0 held for two writes
    first_low = -1; rel = -1; ack_i = -1; second = -1;
    @(posedge clk); #1;
    req0_b = 1; we0_b = 1; adr0_b = 4'h9; wdat0_b = 8'hC3;
    for (int i = 0; i < 60 && second < 0; i++) begin
      @(negedge clk);
      if (!nwr_b && first_low < 0) first_low = i;
      else if (first_low >= 0 && rel < 0 && nwr_b) rel = i;
      else if (rel >= 0 && second < 0 && !nwr_b) second = i;
      if (ack0_b && ack_i < 0) ack_i = i;
    end
    req0_b = 0;
    check("b_first_low", first_low, 1);
    check("b_width", rel - first_low, S2);
    check("b_ack_latency", ack_i, S2 + 1);
    check("b_gap", second - rel, R2 + 1);
    check("b_adr", a_out_b, 4'h9);
    check("b_dout", d_out_b, 8'hC3);
    check("b_nrd", nrd_b, 1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!busy_b) break;
    end
    check("b_idle", busy_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
